// File: rtl/pulse_to_level_pkg.sv
// Shared state encoding and default configuration for the pulse-to-level converter.
package pulse_to_level_pkg;

  // Episode state: waiting, holding the level, or the single abort cycle.
  typedef enum logic [1:0] {
    P2L_IDLE  = 2'd0,
    P2L_HIGH  = 2'd1,
    P2L_ABORT = 2'd2
  } p2l_state_e;

  localparam int P2L_DEF_WIDTH    = 8;
  localparam int P2L_DEF_MIN_HIGH = 1;
  localparam int P2L_DEF_TIMEOUT  = 200;

endpackage

// File: rtl/pulse_to_level_sat_counter.sv
// Saturating up-counter with synchronous load, used to measure how long the
// level has been held.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_to_level.sv
// Turns a one-cycle start strobe into a held enable level that drops on a
// one-cycle done strobe, with a minimum high time, a timeout abort and a
// measured-length report.
//
// Strobe semantics: start and done are single-cycle pulses sampled on every
// rising edge with no back-pressure; start is accepted only in IDLE (otherwise
// it only raises overrun), done only in HIGH. len_valid is a one-cycle strobe
// and len_out is meaningful in that cycle and holds until the next strobe.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int WIDTH    = P2L_DEF_WIDTH,
  parameter int MIN_HIGH = P2L_DEF_MIN_HIGH,
  parameter int TIMEOUT  = P2L_DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  output logic             out,
  output logic             busy,
  output logic [WIDTH-1:0] len_out,
  output logic             len_valid,
  output logic             timeout_err,
  output logic             overrun,
  output p2l_state_e       state_dbg
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_HIGH);
  localparam logic [WIDTH-1:0] TO_C  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  p2l_state_e       state_q, state_d;
  logic             out_q, out_d;
  logic [WIDTH-1:0] len_out_q, len_out_d;
  logic             len_valid_q, len_valid_d;
  logic             terr_q, terr_d;
  logic             ovr_q, ovr_d;
  logic             done_pend_q, done_pend_d;

  logic             cnt_load;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt;
  logic             finish;

  // cnt equals the number of cycles out has been high, including this one.
  sat_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (ONE_C),
    .inc_i      (cnt_inc),
    .cnt_o      (cnt)
  );

  // A completion (now or remembered) ends the episode once the minimum is met.
  // A remembered one was taken below MIN_HIGH, so it matures exactly there.
  assign finish = (done && (cnt >= MIN_C)) || (done_pend_q && (cnt == MIN_C));

  // Next-state and next-output logic for the episode FSM.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    len_out_d   = len_out_q;
    len_valid_d = 1'b0;
    terr_d      = terr_q;
    ovr_d       = ovr_q;
    done_pend_d = done_pend_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      P2L_IDLE: begin
        if (start) begin
          state_d     = P2L_HIGH;
          out_d       = 1'b1;
          cnt_load    = 1'b1;
          terr_d      = 1'b0;
          ovr_d       = 1'b0;
          done_pend_d = 1'b0;
        end
      end
      P2L_HIGH: begin
        cnt_inc = 1'b1;
        if (start) begin
          ovr_d = 1'b1;
        end
        if (finish) begin
          state_d     = P2L_IDLE;
          out_d       = 1'b0;
          len_out_d   = cnt;
          len_valid_d = 1'b1;
          done_pend_d = 1'b0;
        end else if (done) begin
          // Early completion: hold the level until MIN_HIGH is reached.
          done_pend_d = 1'b1;
        end else if (!done_pend_q && (cnt == TO_C)) begin
          state_d     = P2L_ABORT;
          out_d       = 1'b0;
          terr_d      = 1'b1;
          len_out_d   = TO_C;
          len_valid_d = 1'b1;
        end
      end
      P2L_ABORT: begin
        state_d = P2L_IDLE;
        if (start) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = P2L_IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the level without a length report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= P2L_IDLE;
      out_q       <= 1'b0;
      len_out_q   <= '0;
      len_valid_q <= 1'b0;
      terr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      len_out_q   <= len_out_d;
      len_valid_q <= len_valid_d;
      terr_q      <= terr_d;
      ovr_q       <= ovr_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign out         = out_q;
  assign busy        = (state_q != P2L_IDLE);
  assign len_out     = len_out_q;
  assign len_valid   = len_valid_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;
  assign state_dbg   = state_q;

endmodule
